sd_cmd_ctrl: RTL and testbench

//  Sequences one SD command transaction: launch command TX, arm the response

---
 rtl/sd_cmd_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sd_cmd_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_ctrl.sv
// SD command sequencer: send, await response with timeout, report. No-response commands finish 2 cycles after tx_done; cmd_start while busy is dropped.
// Define SD_CMD_RETRY_EN to resend the latched command after a CRC error or timeout, at most MAX_RETRY extra times.
module sd_cmd_ctrl #(
    parameter int TIMEOUT_CYC = 1024
`ifdef SD_CMD_RETRY_EN
    ,
    parameter int MAX_RETRY   = 2
`endif
) (
    input  logic         ex_clk,
    input  logic         reset,
    input  logic         cmd_start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    output logic         tx_start,
    output logic [5:0]   tx_index,
    output logic [31:0]  tx_arg,
    input  logic         tx_done,
    output logic         receive_en,
    output logic         R2_response,
    output logic         R3_response,
    input  logic         sd_receive_started,
    input  logic         sd_receive_finished,
    input  logic         crc_err,
    input  logic [126:0] response,
    output logic [126:0] resp_data,
    output logic         busy,
    output logic         done,
    output logic         err_crc,
    output logic         err_timeout
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, RX, CHECK, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           rx_seen, rx_seen_nxt;
    logic [1:0]     rtype, rtype_nxt;
    logic [5:0]     tx_index_nxt;
    logic [31:0]    tx_arg_nxt;
    logic [126:0]   resp_data_nxt;
    logic           tx_start_nxt, receive_en_nxt, r2_nxt, r3_nxt;
    logic           busy_nxt, done_nxt, err_crc_nxt, err_timeout_nxt;
`ifdef SD_CMD_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0]  retry_cnt, retry_cnt_nxt;
`endif

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        rx_seen_nxt     = rx_seen;
        rtype_nxt       = rtype;
        tx_index_nxt    = tx_index;
        tx_arg_nxt      = tx_arg;
        resp_data_nxt   = resp_data;
        tx_start_nxt    = 1'b0;
        receive_en_nxt  = receive_en;
        r2_nxt          = R2_response;
        r3_nxt          = R3_response;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        err_crc_nxt     = err_crc;
        err_timeout_nxt = err_timeout;
`ifdef SD_CMD_RETRY_EN
        retry_cnt_nxt   = retry_cnt;
`endif
        case (state)
            IDLE: if (cmd_start) begin
                tx_index_nxt    = cmd_index;
                tx_arg_nxt      = cmd_arg;
                rtype_nxt       = resp_type;
                r2_nxt          = (resp_type == 2'd2);
                r3_nxt          = (resp_type == 2'd3);
                err_crc_nxt     = 1'b0;
                err_timeout_nxt = 1'b0;
                busy_nxt        = 1'b1;
`ifdef SD_CMD_RETRY_EN
                retry_cnt_nxt   = '0;
`endif
                state_nxt       = SEND;
            end
            SEND: begin
                tx_start_nxt = 1'b1;
                state_nxt    = WAIT_TX;
            end
            WAIT_TX: if (tx_done) begin
                if (rtype == 2'd0) begin
                    state_nxt = DONE;
                end else begin
                    receive_en_nxt = 1'b1;
                    cnt_nxt        = '0;
                    rx_seen_nxt    = 1'b0;
                    state_nxt      = RX;
                end
            end
            RX: begin
                // A finishing response beats a timeout landing in the same cycle.
                if (sd_receive_finished) begin
                    resp_data_nxt  = response;
                    err_crc_nxt    = crc_err;
                    receive_en_nxt = 1'b0;
                    state_nxt      = CHECK;
                end else if (!rx_seen && !sd_receive_started &&
                             cnt == CW'(TIMEOUT_CYC - 1)) begin
                    err_timeout_nxt = 1'b1;
                    receive_en_nxt  = 1'b0;
                    state_nxt       = CHECK;
                end else if (rx_seen || sd_receive_started) begin
                    rx_seen_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            CHECK: begin
                state_nxt = DONE;
`ifdef SD_CMD_RETRY_EN
                if ((err_crc || err_timeout) && retry_cnt < RW'(MAX_RETRY)) begin
                    retry_cnt_nxt   = retry_cnt + RW'(1);
                    err_crc_nxt     = 1'b0;
                    err_timeout_nxt = 1'b0;
                    state_nxt       = SEND;
                end
`endif
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ex_clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rx_seen     <= 1'b0;
            rtype       <= 2'd0;
            tx_index    <= '0;
            tx_arg      <= '0;
            resp_data   <= '0;
            tx_start    <= 1'b0;
            receive_en  <= 1'b0;
            R2_response <= 1'b0;
            R3_response <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_crc     <= 1'b0;
            err_timeout <= 1'b0;
`ifdef SD_CMD_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rx_seen     <= rx_seen_nxt;
            rtype       <= rtype_nxt;
            tx_index    <= tx_index_nxt;
            tx_arg      <= tx_arg_nxt;
            resp_data   <= resp_data_nxt;
            tx_start    <= tx_start_nxt;
            receive_en  <= receive_en_nxt;
            R2_response <= r2_nxt;
            R3_response <= r3_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err_crc     <= err_crc_nxt;
            err_timeout <= err_timeout_nxt;
`ifdef SD_CMD_RETRY_EN
            retry_cnt   <= retry_cnt_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl with TIMEOUT_CYC = 16.
module tb_sd_cmd_ctrl;
`ifdef SD_CMD_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic         ex_clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_start = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         tx_start;
    logic [5:0]   tx_index;
    logic [31:0]  tx_arg;
    logic         tx_done = 1'b0;
    logic         receive_en, R2_response, R3_response;
    logic         sd_receive_started = 1'b0;
    logic         sd_receive_finished = 1'b0;
    logic         crc_err = 1'b0;
    logic [126:0] response = '0;
    logic [126:0] resp_data;
    logic         busy, done, err_crc, err_timeout;

    int total = 0;
    int bad = 0;
    int tx_cnt = 0;
    int done_cnt = 0;
    int ren_cnt = 0;

    sd_cmd_ctrl #(.TIMEOUT_CYC(16)) dut (
        .ex_clk(ex_clk), .reset(reset), .cmd_start(cmd_start),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type),
        .tx_start(tx_start), .tx_index(tx_index), .tx_arg(tx_arg),
        .tx_done(tx_done), .receive_en(receive_en),
        .R2_response(R2_response), .R3_response(R3_response),
        .sd_receive_started(sd_receive_started),
        .sd_receive_finished(sd_receive_finished), .crc_err(crc_err),
        .response(response), .resp_data(resp_data), .busy(busy),
        .done(done), .err_crc(err_crc), .err_timeout(err_timeout)
    );

    always #5 ex_clk = ~ex_clk;

    always @(posedge ex_clk) begin
        if (tx_start)   tx_cnt   = tx_cnt + 1;
        if (done)       done_cnt = done_cnt + 1;
        if (receive_en) ren_cnt  = ren_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ex_clk);
        #1;
    endtask

    task automatic accept(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        cmd_index = idx;
        cmd_arg   = arg;
        resp_type = rt;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    // Waits for the tx_start pulse then answers it with tx_done in the same cycle.
    task automatic send_tx();
        int n = 0;
        while (!tx_start && n < 10) begin
            tick();
            n++;
        end
        if (n == 10) check("tx_start_wait", 0, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check("done_wait", done, 1);
    endtask

    initial begin
        int t0, d0, r0;
        logic [126:0] pat;

        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_receive_en", receive_en, 0);
        check("rst_tx_index_arg", {tx_index, tx_arg}, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_err", {err_crc, err_timeout, R2_response, R3_response}, 0);
        reset = 1'b0;
        tick();

        // 1: no response, tx_done 5 cycles after accept
        t0 = tx_cnt; r0 = ren_cnt;
        accept(6'd0, 32'd0, 2'd0);
        check("t1_busy", busy, 1);
        repeat (5) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("t1_done_early", done, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_busy_low", busy, 0);
        check("t1_err", {err_crc, err_timeout}, 0);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_tx_count", tx_cnt - t0, 1);
        check("t1_no_receive_en", ren_cnt - r0, 0);

        // 2: R1 response, good CRC
        pat = {63'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};
        accept(6'd8, 32'h1AA, 2'd1);
        send_tx();
        check("t2_receive_en", receive_en, 1);
        check("t2_tx_index", tx_index, 8);
        check("t2_tx_arg", tx_arg, 32'h1AA);
        check("t2_r2r3", {R2_response, R3_response}, 0);
        sd_receive_started = 1'b1;
        tick();
        sd_receive_started = 1'b0;
        tick();
        response = pat;
        sd_receive_finished = 1'b1;
        tick();
        sd_receive_finished = 1'b0;
        check("t2_resp_data", resp_data, pat);
        check("t2_receive_en_drop", receive_en, 0);
        wait_done();
        check("t2_err", {err_crc, err_timeout}, 0);
        tick();

        // 3: R2 with CRC error on every attempt
        t0 = tx_cnt;
        accept(6'd2, 32'h0, 2'd2);
        for (int a = 0; a < ATTEMPTS; a++) begin
            send_tx();
            check("t3_r2", R2_response, 1);
            tick();
            response = 127'h55;
            crc_err = 1'b1;
            sd_receive_finished = 1'b1;
            tick();
            sd_receive_finished = 1'b0;
            crc_err = 1'b0;
        end
        wait_done();
        check("t3_err_crc", err_crc, 1);
        check("t3_err_timeout", err_timeout, 0);
        check("t3_tx_count", tx_cnt - t0, ATTEMPTS);
        tick();

        // 4: R3 with no start bit -> timeout 16 cycles after receive_en rises
        accept(6'd41, 32'h00FF_8000, 2'd3);
        for (int a = 0; a < ATTEMPTS; a++) begin
            send_tx();
            check("t4_r3", R3_response, 1);
            repeat (15) tick();
            check("t4_no_timeout_yet", {receive_en, err_timeout}, 2'b10);
            tick();
            check("t4_timeout", {receive_en, err_timeout}, 2'b01);
        end
        wait_done();
        check("t4_err_timeout", err_timeout, 1);
        tick();

        // 5: cmd_start during RX is ignored
        d0 = done_cnt;
        accept(6'd5, 32'h55, 2'd1);
        send_tx();
        tick();
        cmd_index = 6'd9;
        cmd_arg = 32'hDEAD;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("t5_tx_index", tx_index, 5);
        check("t5_tx_arg", tx_arg, 32'h55);
        sd_receive_finished = 1'b1;
        tick();
        sd_receive_finished = 1'b0;
        wait_done();
        repeat (4) tick();
        check("t5_one_done", done_cnt - d0, 1);
        check("t5_idle", busy, 0);

        // 5b: reset in WAIT_TX aborts without done
        d0 = done_cnt;
        accept(6'd7, 32'h77, 2'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5b_busy", busy, 0);
        check("t5b_tx_index_arg", {tx_index, tx_arg}, 0);
        check("t5b_flags", {tx_start, receive_en, R2_response, R3_response, done}, 0);
        check("t5b_resp_data", resp_data, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (4) tick();
        check("t5b_no_done", done_cnt - d0, 0);
        check("t5b_still_idle", {busy, receive_en}, 0);

        // 6: finish lands on the timeout cycle -> finish wins
        pat = {63'h7AAA_0000_1111_2222, 64'h3333_4444_5555_6666};
        accept(6'd17, 32'h1, 2'd1);
        send_tx();
        repeat (15) tick();
        response = pat;
        sd_receive_finished = 1'b1;
        tick();
        sd_receive_finished = 1'b0;
        check("t6_err_timeout", err_timeout, 0);
        check("t6_err_crc", err_crc, 0);
        check("t6_resp_data", resp_data, pat);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
